uop_issue_queue: RTL and testbench
==================================

Name: uop_issue_queue

Overview:
In-order FIFO buffer between the uop source (decoder/bench) and the register file controller's uop interface (command_kind/command_operand1/command_operand2).
- Absorbs bursts while the register file controller or ALU reservation station stalls.
- Drops NOP uops and supports a synchronous pipeline flush.
- Presents the oldest uop with a valid/ready handshake.

Parameters:
DEPTH, 4, number of uop entries; must be >= 2, need not be a power of two
KIND_WIDTH, 3, width of uop kind field
REGISTER_COUNT, 4, architectural registers; operand1 width = $clog2(REGISTER_COUNT)
OPERAND2_WIDTH, 4, width of operand2 field (immediate or register index)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous discard of all queued uops
in_valid  input  1  upstream uop present
in_ready  output  1  queue can accept a uop this cycle
in_kind  input  KIND_WIDTH  uop kind; value 0 = NOP
in_operand1  input  $clog2(REGISTER_COUNT)  uop operand1
in_operand2  input  OPERAND2_WIDTH  uop operand2
out_valid  output  1  head uop valid
out_ready  input  1  register file controller accepts head uop
out_kind  output  KIND_WIDTH  head uop kind
out_operand1  output  $clog2(REGISTER_COUNT)  head uop operand1
out_operand2  output  OPERAND2_WIDTH  head uop operand2
count  output  $clog2(DEPTH+1)  number of stored uops

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- Reset state: head=0, tail=0, count=0.
- Outputs during reset and while empty: out_valid=0, out_kind/out_operand1/out_operand2=0.
- in_ready = rst_n & !flush & (count < DEPTH). It does not depend on out_ready, so no full-plus-pop pass-through.
- push = in_valid & in_ready & (in_kind != 0).
  - Write entry[tail]; tail advances, wrapping from DEPTH-1 to 0.
- NOP: in_valid & in_ready & in_kind==0 is accepted (handshake completes) but not stored. count, tail and the outputs are unchanged.
- pop = out_valid & out_ready.
  - head advances, wrapping from DEPTH-1 to 0.
- out_valid = (count != 0). Output fields are driven combinationally from entry[head], gated to 0 when empty.
- Count update:
  - push & pop: count unchanged, both pointers advance.
  - push only: +1.
  - pop only: -1.
- Latency: uop pushed at edge N is visible on out_* from cycle N+1 if the queue was empty; otherwise after all older uops are popped.
- Order is strictly FIFO. Outputs are held stable while out_valid & !out_ready.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop that cycle frees the slot next cycle.
- Empty: out_ready is ignored; count never underflows.
- flush (priority: reset > flush > push/pop):
  - Next state is head=tail=count=0.
  - A same-cycle pop is not reported as accepted; out_valid still reflects pre-flush state that cycle.
  - Push is blocked because in_ready=0.
- Reset mid-operation: all entries are discarded and state returns to reset values at the next edge.
- Entry storage contents are not reset; only pointers and count are.

Optional Feature:
UOP_QUEUE_BYPASS_EN
- Defined: when count==0 and in_valid & in_kind!=0 & !flush, the input fields appear on out_* in the same cycle with out_valid=1.
  - If out_ready=1 that cycle, the uop is consumed without being stored: count and pointers unchanged.
  - Otherwise it is stored as a normal push.
  - This creates a combinational in->out path, giving zero-cycle latency when empty.
- Undefined: no bypass; minimum latency is one cycle as described above.

Test Plan:
- Reset then push kind=1,op1=2,op2=5 with out_ready=0 -> next cycle out_valid=1, out_kind=1, out_operand1=2, out_operand2=5, count=1; outputs held for 3 stall cycles.
- Fill (DEPTH=4): push kinds 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; a 5th push of kind 5 is ignored; popping 4 times yields 1,2,3,4 in order.
- Wrap-around: push 3, pop 3, then push 4 and pop 4 -> pointers wrap correctly, order preserved, count returns to 0.
- Simultaneous push/pop at count=2 -> count stays 2; the popped uop is the oldest; the new uop is last.
- NOP: in_valid=1, in_kind=0 -> in_ready=1, count unchanged, out_valid stays 0.
- Flush at count=3 with in_valid=1 kind=2 -> in_ready=0 that cycle; next cycle count=0, out_valid=0. With UOP_QUEUE_BYPASS_EN, an empty queue with in_valid & out_ready shows the uop on out_* in the same cycle and count stays 0.

Source files
------------

// File: rtl/uop_issue_queue.sv
// In-order uop FIFO between decoder and register file controller.
// Optional same-cycle empty-queue bypass: define UOP_QUEUE_BYPASS_EN.
module uop_issue_queue #(
  parameter int DEPTH          = 4,
  parameter int KIND_WIDTH     = 3,
  parameter int REGISTER_COUNT = 4,
  parameter int OPERAND2_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [KIND_WIDTH-1:0]             in_kind,
  input  logic [$clog2(REGISTER_COUNT)-1:0] in_operand1,
  input  logic [OPERAND2_WIDTH-1:0]         in_operand2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [KIND_WIDTH-1:0]             out_kind,
  output logic [$clog2(REGISTER_COUNT)-1:0] out_operand1,
  output logic [OPERAND2_WIDTH-1:0]         out_operand2,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int OW1 = $clog2(REGISTER_COUNT);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);

  logic [KIND_WIDTH-1:0]     kind_q [DEPTH];
  logic [OW1-1:0]            op1_q  [DEPTH];
  logic [OPERAND2_WIDTH-1:0] op2_q  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic stored_valid;
  logic bypass;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready     = rst_n & ~flush & (cnt < CW'(DEPTH));
  assign stored_valid = rst_n & (cnt != '0);

`ifdef UOP_QUEUE_BYPASS_EN
  assign bypass = rst_n & ~flush & (cnt == '0)
                & in_valid & (in_kind != '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = stored_valid | bypass;
  assign pop       = stored_valid & out_ready & ~flush;
  // A bypassed uop taken this cycle never lands in storage
  assign push      = in_valid & in_ready & (in_kind != '0)
                   & ~(bypass & out_ready);
  assign count     = cnt;

  // Head entry, or the bypassed input, zeroed when nothing is valid
  always_comb begin
    out_kind     = '0;
    out_operand1 = '0;
    out_operand2 = '0;
    if (stored_valid) begin
      out_kind     = kind_q[head];
      out_operand1 = op1_q[head];
      out_operand2 = op2_q[head];
    end else if (bypass) begin
      out_kind     = in_kind;
      out_operand1 = in_operand1;
      out_operand2 = in_operand2;
    end
  end

  // Entry storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      kind_q[tail] <= in_kind;
      op1_q[tail]  <= in_operand1;
      op2_q[tail]  <= in_operand2;
    end
  end

  // Pointers and occupancy; reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      unique case (1'b1)
        push & ~pop: cnt <= cnt + CW'(1);
        pop & ~push: cnt <= cnt - CW'(1);
        default:     cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Self-checking bench for uop_issue_queue.
// Directed scenarios plus randomized traffic against a queue model.
module tb_uop_issue_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_kind;
  logic [1:0] in_operand1;
  logic [3:0] in_operand2;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_kind;
  logic [1:0] out_operand1;
  logic [3:0] out_operand2;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] k;
    logic [1:0] a;
    logic [3:0] b;
  } uop_t;

  uop_t mq[$];

  always #5 clk = ~clk;

  uop_issue_queue #(
    .DEPTH(DEPTH), .KIND_WIDTH(3),
    .REGISTER_COUNT(4), .OPERAND2_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_operand1(in_operand1),
    .in_operand2(in_operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .count(count)
  );

  function automatic bit model_bypass();
`ifdef UOP_QUEUE_BYPASS_EN
    return rst_n && !flush && mq.size() == 0
        && in_valid && in_kind != 0;
`else
    return 1'b0;
`endif
  endfunction

  // advance model and clock; inputs are sampled as held
  task automatic tick();
    bit pop_ok, push_ok, byp;
    int n;
    n = mq.size();
    byp = model_bypass() && out_ready;
    pop_ok = rst_n && !flush && n > 0 && out_ready;
    push_ok = rst_n && !flush && n < DEPTH && in_valid
           && in_kind != 0 && !byp;
    @(posedge clk);
    if (!rst_n || flush) mq.delete();
    else begin
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back({in_kind, in_operand1, in_operand2});
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_kind = 0;
    in_operand1 = 0; in_operand2 = 0; out_ready = 0;
  endtask

  task automatic push_one(input int k, input int a, input int b);
    in_valid = 1; in_kind = 3'(k);
    in_operand1 = 2'(a); in_operand2 = 4'(b);
    out_ready = 0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); in_valid = 1; in_kind = 3;
    tick(); tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_kind !== 3'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b k=%0d want v=0 k=0",
               out_valid, out_kind);
    end
    rst_n = 1; idle(); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got c=%0d v=%b r=%b want 0 0 1",
               count, out_valid, in_ready);
    end
  endtask

  task automatic test_hold();
    push_one(1, 2, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_kind !== 3'd1 ||
          out_operand1 !== 2'd2 || out_operand2 !== 4'd5 ||
          count !== 3'd1) begin
        errors++;
        $display("FAIL hold[%0d] got v=%b k=%0d a=%0d b=%0d c=%0d want 1 1 2 5 1",
                 i, out_valid, out_kind, out_operand1, out_operand2, count);
      end
      if (i < 3) tick();
    end
    out_ready = 1; tick(); idle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain got c=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 4; k++) push_one(k, k % 4, k + 8);
    #1;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got c=%0d r=%b want 4 0", count, in_ready);
    end
    push_one(5, 1, 1);
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL fill_ignore got c=%0d want 4", count);
    end
    for (int k = 1; k <= 4; k++) begin
      out_ready = 1; #1;
      checks++;
      if (out_valid !== 1'b1 || out_kind !== 3'(k) ||
          out_operand2 !== 4'(k + 8)) begin
        errors++;
        $display("FAIL fill_order[%0d] got v=%b k=%0d b=%0d want 1 %0d %0d",
                 k, out_valid, out_kind, out_operand2, k, k + 8);
      end
      tick();
    end
    idle();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL fill_empty got c=%0d want 0", count);
    end
  endtask

  task automatic test_wrap();
    int pushes [2] = '{3, 4};
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= pushes[r]; k++) push_one(k + r, k, k * 3);
      for (int k = 1; k <= pushes[r]; k++) begin
        out_ready = 1; #1;
        checks++;
        if (out_kind !== 3'(k + r) || out_operand1 !== 2'(k) ||
            out_operand2 !== 4'(k * 3)) begin
          errors++;
          $display("FAIL wrap[%0d.%0d] got k=%0d a=%0d b=%0d want %0d %0d %0d",
                   r, k, out_kind, out_operand1, out_operand2,
                   k + r, k % 4, (k * 3) % 16);
        end
        tick();
      end
      idle();
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty got c=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_push_pop();
    push_one(6, 1, 1);
    push_one(7, 2, 2);
    in_valid = 1; in_kind = 3; in_operand1 = 3; in_operand2 = 3;
    out_ready = 1; #1;
    checks++;
    if (out_kind !== 3'd6) begin
      errors++; $display("FAIL pp_oldest got k=%0d want 6", out_kind);
    end
    tick(); idle();
    checks++;
    if (count !== 3'd2 || out_kind !== 3'd7) begin
      errors++;
      $display("FAIL pp_after got c=%0d k=%0d want 2 7", count, out_kind);
    end
    out_ready = 1; tick();
    checks++;
    if (out_kind !== 3'd3 || count !== 3'd1) begin
      errors++;
      $display("FAIL pp_last got k=%0d c=%0d want 3 1", out_kind, count);
    end
    tick(); idle();
  endtask

  task automatic test_nop();
    in_valid = 1; in_kind = 0; in_operand1 = 1; in_operand2 = 9;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL nop_ready got %b want 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop_state got c=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) push_one(k, 0, k);
    flush = 1; in_valid = 1; in_kind = 2; out_ready = 1; #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle got r=%b v=%b want 0 1", in_ready, out_valid);
    end
    tick(); idle(); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after got c=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

`ifdef UOP_QUEUE_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1; in_kind = 3; in_operand1 = 1; in_operand2 = 7;
    out_ready = 1; #1;
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 3'd3 || out_operand2 !== 4'd7) begin
      errors++;
      $display("FAIL bypass_same got v=%b k=%0d b=%0d want 1 3 7",
               out_valid, out_kind, out_operand2);
    end
    tick(); idle();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL bypass_count got c=%0d want 0", count);
    end
  endtask
`endif

  task automatic test_random();
    uop_t exp;
    bit ev, er;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(99) >= 2);
      flush = ($urandom_range(99) < 5);
      in_valid = ($urandom_range(99) < 70);
      in_kind = 3'($urandom_range(7));
      in_operand1 = 2'($urandom);
      in_operand2 = 4'($urandom);
      out_ready = ($urandom_range(99) < 45);
      #1;
      er = rst_n && !flush && mq.size() < DEPTH;
      ev = rst_n && (mq.size() > 0 || model_bypass());
      exp = '0;
      if (rst_n && mq.size() > 0) exp = mq[0];
      else if (model_bypass()) exp = {in_kind, in_operand1, in_operand2};
      checks++;
      if (in_ready !== er || out_valid !== ev ||
          count !== 3'(mq.size()) ||
          {out_kind, out_operand1, out_operand2} !== exp) begin
        errors++;
        $display("FAIL rand[%0d] got r=%b v=%b c=%0d u=%h want %b %b %0d %h",
                 i, in_ready, out_valid, count,
                 {out_kind, out_operand1, out_operand2},
                 er, ev, mq.size(), exp);
      end
      tick();
    end
    rst_n = 1; idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_hold();
    test_fill();
    test_wrap();
    test_push_pop();
    test_nop();
    test_flush();
`ifdef UOP_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
